rx_fifo_uart: RTL

//  Parametrised UART receiver, successor to the single-byte rx: configurable data width,

---
 rtl/uart_pkg.sv | 33 +++
 rtl/rx_fifo_uart_if.sv | 29 ++
 rtl/rx_fifo.sv | 48 ++++
 rtl/rx_fifo_uart.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the FIFO-backed UART receiver: parity modes, receiver states,
// the stored frame entry and the bit-period helper.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    PUSH
  } rx_state_e;

  // Entries are sized for the widest frame; narrower builds zero the upper data bits.
  localparam int MAX_DATA_BITS = 9;

  typedef struct packed {
    logic [MAX_DATA_BITS-1:0] data;
    logic                     parity_err;
    logic                     framing_err;
  } rx_entry_t;

  function automatic int bit_cycles(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/rx_fifo_uart_if.sv
// Host-side receive handshake of rx_fifo_uart: head-of-FIFO data plus status flags.
interface rx_fifo_uart_if #(
  parameter int DATA_BITS = 8
);
  // Four-phase handshake: Receive (valid) is high while a head entry is offered;
  // the consumer raises ReceiveAck to take it, Receive drops the next cycle, and the
  // next entry is offered only after ReceiveAck returns low.
  logic                 Receive;
  logic                 ReceiveAck;
  logic [DATA_BITS-1:0] Dout;
  logic                 parityErr;
  logic                 framingErr;

  modport master (
    output Receive,
    output Dout,
    output parityErr,
    output framingErr,
    input  ReceiveAck
  );

  modport slave (
    input  Receive,
    input  Dout,
    input  parityErr,
    input  framingErr,
    output ReceiveAck
  );
endinterface

// File: rtl/rx_fifo.sv
// Synchronous FIFO of received frame entries; pointers carry an extra wrap bit
// so full and empty are distinguished without a separate counter.
module rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  rx_entry_t                wdata,
  input  logic                     pop,
  output rx_entry_t                rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  rx_entry_t   mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/rx_fifo_uart.sv
// Parametrised UART receiver with per-frame status and a receive FIFO.
// Optional RX_MAJORITY_VOTE_EN: 2-of-3 vote around each mid-bit sample point.
module rx_fifo_uart
  import uart_pkg::*;
#(
  parameter int      CLK_FREQUENCY = 100_000_000,
  parameter int      BAUD_RATE     = 19_200,
  parameter int      DATA_BITS     = 8,
  parameter parity_e PARITY_MODE   = PAR_ODD,
  parameter int      STOP_BITS     = 1,
  parameter int      FIFO_DEPTH    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          Sin,
  rx_fifo_uart_if.master                host,
  output logic                          overrun,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output rx_state_e                     state
);
  localparam int BIT_CYCLES = bit_cycles(CLK_FREQUENCY, BAUD_RATE);
  localparam int CW         = $clog2(BIT_CYCLES + 1);

  logic sin_meta, sin_sync, sin_d1;
  logic bit_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      sin_meta <= 1'b1;
      sin_sync <= 1'b1;
      sin_d1   <= 1'b1;
    end else begin
      sin_meta <= Sin;
      sin_sync <= sin_meta;
      sin_d1   <= sin_sync;
    end
  end

`ifdef RX_MAJORITY_VOTE_EN
  localparam int VOTE_DELAY = 1;
  logic sin_d2;
  always_ff @(posedge clk) begin
    if (rst) sin_d2 <= 1'b1;
    else     sin_d2 <= sin_d1;
  end
  // Sampling one cycle late puts mid-1, mid and mid+1 in d2, d1 and sync.
  assign bit_val = (sin_sync & sin_d1) | (sin_sync & sin_d2) | (sin_d1 & sin_d2);
`else
  localparam int VOTE_DELAY = 0;
  assign bit_val = sin_sync;
`endif

  localparam int HALF_LOAD = BIT_CYCLES / 2 - 1 + VOTE_DELAY;
  localparam int BIT_LOAD  = BIT_CYCLES - 1;

  rx_state_e              state_next;
  logic [CW-1:0]          baud_cnt;
  logic [3:0]             bit_cnt;
  logic [DATA_BITS-1:0]   shreg;
  logic                   par_bit;
  logic                   ferr;
  logic                   start_edge;
  logic                   tick;

  assign start_edge = sin_d1 & ~sin_sync;
  assign tick       = (baud_cnt == '0);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (start_edge) state_next = START;
      START:  if (tick) state_next = bit_val ? IDLE : DATA;
      DATA:   if (tick && bit_cnt == 4'(DATA_BITS - 1))
                state_next = (PARITY_MODE == PAR_NONE) ? STOP : PARITY;
      PARITY: if (tick) state_next = STOP;
      STOP:   if (tick && bit_cnt == 4'(STOP_BITS - 1)) state_next = PUSH;
      PUSH:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      ferr     <= 1'b0;
    end else begin
      if (state == IDLE)  baud_cnt <= CW'(HALF_LOAD);
      else if (tick)      baud_cnt <= CW'(BIT_LOAD);
      else                baud_cnt <= baud_cnt - 1'b1;

      // The bit counter only restarts on a state change, never by itself.
      if (state_next != state)                      bit_cnt <= '0;
      else if (tick && (state == DATA || state == STOP)) bit_cnt <= bit_cnt + 1'b1;

      if (state == IDLE)                  ferr    <= 1'b0;
      else if (state == STOP && tick && !bit_val) ferr <= 1'b1;

      if (state == DATA && tick)   shreg   <= {bit_val, shreg[DATA_BITS-1:1]};
      if (state == PARITY && tick) par_bit <= bit_val;
    end
  end

  rx_entry_t wdata;
  rx_entry_t head;
  logic      push, pop, full, empty;
  logic      ack_prev, ack_hold;
  logic      unused_head_bits;

  always_comb begin
    wdata                   = '0;
    wdata.data[DATA_BITS-1:0] = shreg;
    wdata.parity_err        = (PARITY_MODE != PAR_NONE) &&
                              ((^{shreg, par_bit}) != (PARITY_MODE == PAR_ODD));
    wdata.framing_err       = ferr;
  end

  assign push = (state == PUSH);
  assign pop  = host.ReceiveAck && !ack_prev && host.Receive;

  rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_prev <= 1'b0;
      ack_hold <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      ack_prev <= host.ReceiveAck;
      if (pop)                   ack_hold <= 1'b1;
      else if (!host.ReceiveAck) ack_hold <= 1'b0;
      if (pop)                   overrun  <= 1'b0;
      else if (push && full)     overrun  <= 1'b1;
    end
  end

  assign host.Receive    = !empty && !ack_hold;
  assign host.Dout       = head.data[DATA_BITS-1:0];
  assign host.parityErr  = head.parity_err;
  assign host.framingErr = head.framing_err;
  assign unused_head_bits = ^head.data;

endmodule
